yuv422_frame_capture: RTL and testbench

- Downstream consumer of the simulated DVD/camera byte stream: active-low vsync, line-valid strobe, 8-bit data, 2 bytes per pixel (UYVY order: Cb, Y0, Cr, Y1).
- Strips the first valid line of each frame as a command line and latches its leading bytes.
- De-interleaves the remaining lines into per-pixel Y/Cb/Cr with frame and line markers.
- Flags malformed frames for the processing pipeline that follows.

---
 rtl/yuv422_frame_capture.sv | 214 +++++++++++++++++++++
 tb/tb_yuv422_frame_capture.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv422_frame_capture.sv
// yuv422_frame_capture: UYVY byte stream to per-pixel Y/Cb/Cr, command line stripped.
// Optional CAP_STATS_EN: frame counter and consecutive line-length check.
module yuv422_frame_capture #(
  parameter int DW        = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 512,
  parameter int CMD_BYTES = 4,
  parameter int DATA_LAG  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vsync,
  input  logic                   in_dvalid,
  input  logic [DW-1:0]          in_data,
  output logic [DW-1:0]          out_y,
  output logic [DW-1:0]          out_cb,
  output logic [DW-1:0]          out_cr,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic [8*CMD_BYTES-1:0] cmd_word,
  output logic                   cmd_valid,
  output logic                   frame_err,
  output logic [15:0]            frame_cnt
);

  localparam int CW = 8*CMD_BYTES;
  localparam logic [15:0] LB = 16'(2*IMG_W);
  localparam logic [15:0] LH = 16'(IMG_H);
  localparam logic [15:0] NC = 16'(CMD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ACTIVE,
    DONE
  } state_t;

  state_t        state_q;
  logic          vs_q, vs2_q, dv_q, dvl_q;
  logic          qvp_q, skip_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] cb_q, y0_q, cr_q, y1_q;
  logic [1:0]    ph_q;
  logic [15:0]   bcnt_q, line_q;
  logic [CW-1:0] csh_q, cw_q;
  logic          pendb_q, beol_q;
  logic [DW-1:0] oy_q, ocb_q, ocr_q;
  logic          ov_q, osof_q, oeol_q;
  logic          cv_q, err_q;

  logic          qv, fs, le;
  logic          take, lend, abort;
  logic [15:0]   bcnt_d;

  assign qv     = (DATA_LAG != 0) ? dvl_q : dv_q;
  assign fs     = vs2_q & ~vs_q;
  assign le     = qvp_q & ~qv;
  assign take   = qv & ~skip_q;
  assign lend   = le & ~skip_q;
  assign abort  = fs & ((state_q == CMD) || (state_q == ACTIVE));
  assign bcnt_d = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

`ifdef CAP_STATS_EN
  logic [15:0] fcnt_q, plen_q;
  logic        hasp_q;
  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign out_y     = oy_q;
  assign out_cb    = ocb_q;
  assign out_cr    = ocr_q;
  assign out_valid = ov_q;
  assign out_sof   = osof_q;
  assign out_eol   = oeol_q;
  assign cmd_word  = cw_q;
  assign cmd_valid = cv_q;
  assign frame_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      vs2_q   <= 1'b0;
      dv_q    <= 1'b0;
      dvl_q   <= 1'b0;
      qvp_q   <= 1'b0;
      skip_q  <= 1'b0;
      data_q  <= '0;
      cb_q    <= '0;
      y0_q    <= '0;
      cr_q    <= '0;
      y1_q    <= '0;
      ph_q    <= '0;
      bcnt_q  <= '0;
      line_q  <= '0;
      csh_q   <= '0;
      cw_q    <= '0;
      pendb_q <= 1'b0;
      beol_q  <= 1'b0;
      oy_q    <= '0;
      ocb_q   <= '0;
      ocr_q   <= '0;
      ov_q    <= 1'b0;
      osof_q  <= 1'b0;
      oeol_q  <= 1'b0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef CAP_STATS_EN
      fcnt_q  <= '0;
      plen_q  <= '0;
      hasp_q  <= 1'b0;
`endif
    end else begin
      vs_q    <= in_vsync;
      vs2_q   <= vs_q;
      dv_q    <= in_dvalid;
      dvl_q   <= dv_q;
      data_q  <= in_data;
      qvp_q   <= qv;
      cv_q    <= 1'b0;
      ov_q    <= 1'b0;
      osof_q  <= 1'b0;
      oeol_q  <= 1'b0;
      pendb_q <= 1'b0;
      if (skip_q && !qv) skip_q <= 1'b0;
      // pixel B reuses the pair's chroma still on the outputs
      if (pendb_q) begin
        ov_q   <= 1'b1;
        oy_q   <= y1_q;
        oeol_q <= beol_q;
      end
      if (fs) begin
        state_q <= CMD;
        line_q  <= '0;
        bcnt_q  <= '0;
        ph_q    <= '0;
        csh_q   <= '0;
        skip_q  <= qv;
        err_q   <= abort;
        ov_q    <= 1'b0;
        oeol_q  <= 1'b0;
`ifdef CAP_STATS_EN
        hasp_q  <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          IDLE: ;
          CMD: begin
            if (lend) begin
              cw_q    <= csh_q;
              cv_q    <= 1'b1;
              state_q <= ACTIVE;
              bcnt_q  <= '0;
              ph_q    <= '0;
              if (bcnt_q < NC) err_q <= 1'b1;
            end else if (take) begin
              for (int i = 0; i < CMD_BYTES; i++) begin
                if (bcnt_q == 16'(i))
                  csh_q[CW-1-8*i -: 8] <= data_q[7:0];
              end
              bcnt_q <= bcnt_d;
            end
          end
          ACTIVE: begin
            if (lend) begin
              if (bcnt_q != LB) err_q <= 1'b1;
`ifdef CAP_STATS_EN
              if (hasp_q && (plen_q != bcnt_q)) err_q <= 1'b1;
              plen_q <= bcnt_q;
              hasp_q <= 1'b1;
`endif
              bcnt_q <= '0;
              ph_q   <= '0;
              line_q <= line_q + 16'd1;
              if (line_q + 16'd1 == LH) begin
                state_q <= DONE;
`ifdef CAP_STATS_EN
                fcnt_q  <= fcnt_q + 16'd1;
`endif
              end
            end else if (take) begin
              bcnt_q <= bcnt_d;
              if (bcnt_q < LB) begin
                ph_q <= ph_q + 2'd1;
                unique case (ph_q)
                  2'd0: cb_q <= data_q;
                  2'd1: y0_q <= data_q;
                  2'd2: cr_q <= data_q;
                  2'd3: begin
                    y1_q    <= data_q;
                    ov_q    <= 1'b1;
                    oy_q    <= y0_q;
                    ocb_q   <= cb_q;
                    ocr_q   <= cr_q;
                    osof_q  <= (line_q == 16'd0) && (bcnt_q == 16'd3);
                    beol_q  <= (bcnt_q == LB - 16'd1);
                    pendb_q <= 1'b1;
                  end
                endcase
              end
            end
          end
          DONE: begin
            if (take) err_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yuv422_frame_capture.sv
// tb_yuv422_frame_capture: random UYVY frames checked against a line-level model.
// Covers nominal, short line, abort, overrun and mid-line reset cases.
module tb_yuv422_frame_capture;

  localparam int DW  = 8;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int CB  = 4;
  localparam int LAG = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_vsync;
  logic        in_dvalid;
  logic [7:0]  in_data;
  logic [7:0]  out_y, out_cb, out_cr;
  logic        out_valid, out_sof, out_eol;
  logic [31:0] cmd_word;
  logic        cmd_valid, frame_err;
  logic [15:0] frame_cnt;

  yuv422_frame_capture #(
    .DW(DW), .IMG_W(W), .IMG_H(H),
    .CMD_BYTES(CB), .DATA_LAG(LAG)
  ) dut (
    .clk(clk), .reset(reset),
    .in_vsync(in_vsync), .in_dvalid(in_dvalid),
    .in_data(in_data),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
    .out_valid(out_valid), .out_sof(out_sof),
    .out_eol(out_eol),
    .cmd_word(cmd_word), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y, cb, cr;
    logic       sof, eol;
    int         t;
  } pix_t;

  int   cc = 0;
  int   nvec = 0, nmis = 0;
  int   ncv = 0, nstray = 0;
  pix_t got_q[$], exp_q[$];
  pix_t mp;

  always @(posedge clk) cc <= cc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      mp.y = out_y; mp.cb = out_cb; mp.cr = out_cr;
      mp.sof = out_sof; mp.eol = out_eol; mp.t = cc;
      got_q.push_back(mp);
    end
    if (!out_valid && (out_sof || out_eol)) nstray++;
    if (cmd_valid) ncv++;
  end

  int          m_line = -1;
  logic        m_err = 1'b0;
  logic [31:0] m_cmd = '0;
  int          m_fcnt = 0, m_plen = -1, m_ncmd = 0;

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    nvec++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [63:0] pk(input pix_t p);
    return 64'({p.y, p.cb, p.cr, p.sof, p.eol});
  endfunction

  task automatic m_reset();
    m_line = -1; m_err = 1'b0; m_cmd = '0;
    m_fcnt = 0; m_plen = -1;
  endtask

  task automatic m_fs();
    m_err  = (m_line >= 0 && m_line <= H);
    m_line = 0;
    m_plen = -1;
  endtask

  task automatic m_proc(input logic [7:0] b[$]);
    int   n, used;
    pix_t p;
    n = b.size();
    if (m_line < 0) return;
    if (m_line == 0) begin
      m_cmd = '0;
      for (int i = 0; i < CB; i++)
        m_cmd = {m_cmd[23:0], (i < n) ? b[i] : 8'h00};
      if (n < CB) m_err = 1'b1;
      m_ncmd++;
    end else if (m_line <= H) begin
      used = (n < 2*W) ? n : 2*W;
      for (int g = 0; g < used/4; g++) begin
        p.cb = b[4*g]; p.cr = b[4*g+2]; p.t = 0;
        p.y = b[4*g+1]; p.sof = (m_line == 1 && g == 0); p.eol = 1'b0;
        exp_q.push_back(p);
        p.y = b[4*g+3]; p.sof = 1'b0; p.eol = (4*g+3 == 2*W-1);
        exp_q.push_back(p);
      end
      if (n != 2*W) m_err = 1'b1;
`ifdef CAP_STATS_EN
      if (m_plen >= 0 && n != m_plen) m_err = 1'b1;
`endif
      m_plen = n;
      if (m_line == H) m_fcnt = (m_fcnt + 1) % 65536;
    end else if (n > 0) m_err = 1'b1;
    m_line++;
  endtask

  logic [7:0] pend = 8'h00;

  task automatic cyc(input logic vs, input logic dv, input logic [7:0] d);
    @(posedge clk); #1;
    in_vsync  = vs;
    in_dvalid = dv;
    in_data   = (LAG == 1) ? pend : d;
    pend      = dv ? d : 8'h00;
  endtask

  task automatic gap(input int n);
    repeat (n) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b[$], output int t3);
    t3 = -1;
    for (int i = 0; i < b.size(); i++) begin
      cyc(1'b1, 1'b1, b[i]);
      if (i == 3) t3 = cc;
    end
    gap(6);
    m_proc(b);
  endtask

  task automatic mk(input int n, output logic [7:0] q[$]);
    q = {};
    repeat (n) q.push_back(8'($urandom));
  endtask

  task automatic fstart();
    cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    m_fs();
    gap(3);
  endtask

  task automatic cmp_pix(input string tag);
    chk({tag, " npix"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, " pix"}, pk(got_q[i]), pk(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic fend(input string tag);
    logic [15:0] fc;
    gap(2);
`ifdef CAP_STATS_EN
    fc = 16'(m_fcnt);
`else
    fc = 16'd0;
`endif
    cmp_pix(tag);
    chk({tag, " cmd_word"}, 64'(cmd_word), 64'(m_cmd));
    chk({tag, " cmd pulses"}, 64'(ncv), 64'(m_ncmd));
    chk({tag, " frame_err"}, 64'(frame_err), 64'(m_err));
    chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'(fc));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " y"}, 64'(out_y), 64'd0);
    chk({tag, " cb"}, 64'(out_cb), 64'd0);
    chk({tag, " cr"}, 64'(out_cr), 64'd0);
    chk({tag, " valid"}, 64'(out_valid), 64'd0);
    chk({tag, " sof"}, 64'(out_sof), 64'd0);
    chk({tag, " eol"}, 64'(out_eol), 64'd0);
    chk({tag, " cmd_word"}, 64'(cmd_word), 64'd0);
    chk({tag, " cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, " frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] grp[$];
    int         t3, dmy, n;
    pix_t       pa;

    reset = 1'b1; in_vsync = 1'b1; in_dvalid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    gap(4);

    // nominal frame with a known first group
    fstart();
    q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(q, dmy);
    mk(4, q);
    grp = {8'h80, 8'h10, 8'h90, 8'h20};
    q = {grp, q};
    send(q, t3);
    mk(2*W, q);
    send(q, dmy);
    gap(2);
    chk("lat A", 64'(got_q.size() > 0 ? got_q[0].t - t3 : -1),
        64'(2 + LAG));
    chk("lat B", 64'(got_q.size() > 1 ? got_q[1].t - got_q[0].t : -1),
        64'd1);
    pa.y = 8'h10; pa.cb = 8'h80; pa.cr = 8'h90;
    pa.sof = 1'b1; pa.eol = 1'b0; pa.t = 0;
    chk("grp A", got_q.size() > 0 ? pk(got_q[0]) : '1, pk(pa));
    pa.y = 8'h20; pa.sof = 1'b0;
    chk("grp B", got_q.size() > 1 ? pk(got_q[1]) : '1, pk(pa));
    fend("nominal");
    chk("cmd const", 64'(cmd_word), 64'hA1B2C3D4);

    // short image line
    fstart();
    mk(CB, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    mk(2*W-2, q); send(q, dmy);
    fend("short");
    fstart();
    chk("err cleared", 64'(frame_err), 64'(m_err));
    mk(CB, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    fend("clean");

    // vsync falls mid-line, dropping pixel B of the open group
    fstart();
    mk(CB, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    cmp_pix("pre-abort");
    mk(2*W, q);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, q[i]);
    cyc(1'b0, 1'b1, q[5]);
    m_fs();
    cyc(1'b0, 1'b1, q[6]);
    cyc(1'b0, 1'b1, q[7]);
    chk("abort valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      chk("abort valid", 64'(out_valid), 64'd0);
    end
    chk("abort npix", 64'(got_q.size()), 64'd1);
    chk("abort eol", 64'(got_q.size() > 0 ? got_q[0].eol : 1'b1), 64'd0);
    got_q.delete();
    chk("abort err", 64'(frame_err), 64'd1);
    mk(CB, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    fend("post-abort");
    fstart();
    chk("err cleared 2", 64'(frame_err), 64'd0);
    mk(CB, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    fend("clean2");

    // one image line too many
    fstart();
    mk(CB, q); send(q, dmy);
    for (int l = 0; l <= H; l++) begin
      mk(2*W, q); send(q, dmy);
    end
    fend("overrun");

    // random frames, some with odd line or command lengths
    for (int f = 0; f < 4; f++) begin
      fstart();
      n = $urandom_range(2, 6);
      mk(n, q); send(q, dmy);
      for (int l = 0; l < H; l++) begin
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : 2*W;
        mk(n, q); send(q, dmy);
      end
      fend("random");
    end

    // reset in the middle of an image line
    fstart();
    mk(2, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    mk(2*W, q);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, q[i]);
    reset = 1'b1;
    cyc(1'b1, 1'b1, q[5]);
    chk_zero("mid reset");
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    m_reset();
    cyc(1'b1, 1'b1, q[6]);
    cyc(1'b1, 1'b1, q[7]);
    gap(6);
    mk(2*W, q); send(q, dmy);
    cmp_pix("idle");
    chk("idle valid", 64'(cmd_word), 64'd0);
    fstart();
    mk(CB, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    mk(2*W, q); send(q, dmy);
    fend("restart");

    chk("stray strobes", 64'(nstray), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
